// File: rtl/dll_pkg.sv
// Shared types and sizing for the FMDLL lock controller.
package dll_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PD_RST,
        ST_MEASURE,
        ST_DECIDE
    } state_t;

    typedef enum logic {
        MODE_SAR,
        MODE_TRACK
    } mode_t;

    localparam int DLL_QW       = 10;
    localparam int DLL_LOCK_CNT = 4;
    localparam int DLL_MW       = 2;
    localparam int DLL_NW       = 4;

endpackage

// File: rtl/dll_window_cnt.sv
// Nested M/N measurement-window counter: counters restart at 1/1, zero counts clamp to 1,
// and done flags the final cycle of the window (counters then hold).
module dll_window_cnt
    import dll_pkg::*;
#(
    parameter int MW = DLL_MW,
    parameter int NW = DLL_NW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          init,
    input  logic          load,
    input  logic          run,
    input  logic [MW-1:0] m_in,
    input  logic [NW-1:0] n_in,
    output logic [MW-1:0] m_cnt,
    output logic [NW-1:0] n_cnt,
    output logic          done
);

    logic [MW-1:0] m_cnt_q, m_cnt_d, m_eff_q, m_eff_d;
    logic [NW-1:0] n_cnt_q, n_cnt_d, n_eff_q, n_eff_d;

    assign done  = (m_cnt_q == m_eff_q) && (n_cnt_q == n_eff_q);
    assign m_cnt = m_cnt_q;
    assign n_cnt = n_cnt_q;

    always_comb begin
        m_cnt_d = m_cnt_q;
        n_cnt_d = n_cnt_q;
        m_eff_d = m_eff_q;
        n_eff_d = n_eff_q;
        if (load) begin
            m_eff_d = (m_in == '0) ? MW'(1) : m_in;
            n_eff_d = (n_in == '0) ? NW'(1) : n_in;
        end
        if (init) begin
            m_cnt_d = MW'(1);
            n_cnt_d = NW'(1);
        end else if (run && !done) begin
            if (n_cnt_q == n_eff_q) begin
                n_cnt_d = NW'(1);
                m_cnt_d = m_cnt_q + MW'(1);
            end else begin
                n_cnt_d = n_cnt_q + NW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_cnt_q <= '0;
            n_cnt_q <= '0;
            m_eff_q <= MW'(1);
            n_eff_q <= NW'(1);
        end else begin
            m_cnt_q <= m_cnt_d;
            n_cnt_q <= n_cnt_d;
            m_eff_q <= m_eff_d;
            n_eff_q <= n_eff_d;
        end
    end

endmodule

// File: rtl/dll_lock_ctrl.sv
// FMDLL lock controller: sequences PD windows, runs SAR acquisition then +/-1 tracking,
// and declares lock after LOCK_CNT consecutive direction reversals.
module dll_lock_ctrl
    import dll_pkg::*;
#(
    parameter int QW       = DLL_QW,
    parameter int LOCK_CNT = DLL_LOCK_CNT
) (
    input  logic                clk_ext,
    input  logic                Reset,
    input  logic                en,
    input  logic                start,
    input  logic [DLL_MW-1:0]   M,
    input  logic [DLL_NW-1:0]   N,
    input  logic                COMP,
    output logic                Reset_PD,
    output logic [DLL_MW-1:0]   M_counter,
    output logic [DLL_NW-1:0]   N_counter,
    output logic [QW-1:0]       Q,
    output logic [QW-1:0]       Q_next,
    output logic                lock,
    output logic                busy
);

    localparam int BW = $clog2(QW);
    localparam int CW = $clog2(LOCK_CNT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(LOCK_CNT);
    localparam logic [QW-1:0] Q_MAX   = '1;
    localparam logic [QW-1:0] Q_FIRST = {1'b1, {(QW-1){1'b0}}};

    state_t        state_q, state_d;
    mode_t         mode_q, mode_d;
    logic [QW-1:0] q_q, q_d;
    logic [BW-1:0] bit_idx_q, bit_idx_d;
    logic [CW-1:0] rev_cnt_q, rev_cnt_d, same_cnt_q, same_cnt_d;
    logic          last_dir_q, last_dir_d, dir_vld_q, dir_vld_d;
    logic          lock_q, lock_d, rpd_q, rpd_d, busy_q, busy_d;

    logic          win_done;
    logic          dir_up;
    logic [QW-1:0] q_sar, q_trk;

    dll_window_cnt #(.MW(DLL_MW), .NW(DLL_NW)) u_win (
        .clk   (clk_ext),
        .rst   (Reset),
        .init  (rpd_d),
        .load  (state_q == ST_PD_RST),
        .run   (state_q == ST_MEASURE),
        .m_in  (M),
        .n_in  (N),
        .m_cnt (M_counter),
        .n_cnt (N_counter),
        .done  (win_done)
    );

    assign dir_up = !COMP;

    // Resolve the current trial bit, then plant the next one below it.
    always_comb begin
        q_sar = q_q;
        if (COMP) q_sar[bit_idx_q] = 1'b0;
        if (bit_idx_q != '0) q_sar[bit_idx_q - BW'(1)] = 1'b1;
    end

    always_comb begin
        q_trk = q_q;
        if (dir_up && q_q != Q_MAX) q_trk = q_q + QW'(1);
        else if (!dir_up && q_q != '0) q_trk = q_q - QW'(1);
    end

    assign Q_next = (state_q != ST_DECIDE) ? q_q :
                    (mode_q == MODE_SAR)   ? q_sar : q_trk;

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        q_d        = q_q;
        bit_idx_d  = bit_idx_q;
        rev_cnt_d  = rev_cnt_q;
        same_cnt_d = same_cnt_q;
        last_dir_d = last_dir_q;
        dir_vld_d  = dir_vld_q;
        lock_d     = lock_q;
        rpd_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && en) begin
                    state_d    = ST_PD_RST;
                    rpd_d      = 1'b1;
                    mode_d     = MODE_SAR;
                    bit_idx_d  = BW'(QW - 1);
                    q_d        = Q_FIRST;
                    lock_d     = 1'b0;
                    rev_cnt_d  = '0;
                    same_cnt_d = '0;
                    last_dir_d = 1'b0;
                    dir_vld_d  = 1'b0;
                end
            end
            ST_PD_RST:  state_d = ST_MEASURE;
            ST_MEASURE: if (win_done) state_d = ST_DECIDE;
            ST_DECIDE: begin
                q_d = Q_next;
                if (mode_q == MODE_SAR) begin
                    if (bit_idx_q == '0) mode_d = MODE_TRACK;
                    else bit_idx_d = bit_idx_q - BW'(1);
                end else begin
                    last_dir_d = dir_up;
                    dir_vld_d  = 1'b1;
                    if (!dir_vld_q) begin
                        rev_cnt_d  = '0;
                        same_cnt_d = '0;
                    end else if (dir_up != last_dir_q) begin
                        rev_cnt_d  = (rev_cnt_q == CNT_MAX) ? CNT_MAX : rev_cnt_q + CW'(1);
                        same_cnt_d = '0;
                        if (rev_cnt_d == CNT_MAX) lock_d = 1'b1;
                    end else begin
                        same_cnt_d = (same_cnt_q == CNT_MAX) ? CNT_MAX : same_cnt_q + CW'(1);
                        rev_cnt_d  = '0;
                        if (same_cnt_d == CNT_MAX) lock_d = 1'b0;
                    end
                end
                state_d = en ? ST_PD_RST : ST_IDLE;
                rpd_d   = en;
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk_ext) begin
        if (Reset) begin
            state_q    <= ST_IDLE;
            mode_q     <= MODE_SAR;
            q_q        <= '0;
            bit_idx_q  <= BW'(QW - 1);
            rev_cnt_q  <= '0;
            same_cnt_q <= '0;
            last_dir_q <= 1'b0;
            dir_vld_q  <= 1'b0;
            lock_q     <= 1'b0;
            rpd_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            q_q        <= q_d;
            bit_idx_q  <= bit_idx_d;
            rev_cnt_q  <= rev_cnt_d;
            same_cnt_q <= same_cnt_d;
            last_dir_q <= last_dir_d;
            dir_vld_q  <= dir_vld_d;
            lock_q     <= lock_d;
            rpd_q      <= rpd_d;
            busy_q     <= busy_d;
        end
    end

    assign Q        = q_q;
    assign lock     = lock_q;
    assign busy     = busy_q;
    assign Reset_PD = rpd_q;

endmodule

// File: tb/tb_dll_lock_ctrl.sv
// Directed bench for dll_lock_ctrl: window sequencing table plus SAR/track/lock sequences.
module tb_dll_lock_ctrl;

    logic       clk_ext = 1'b0;
    logic       Reset, en, start, COMP;
    logic [1:0] M;
    logic [3:0] N;
    logic       Reset_PD, lock, busy;
    logic [1:0] M_counter;
    logic [3:0] N_counter;
    logic [9:0] Q, Q_next;

    int checks = 0;
    int errors = 0;
    bit comp_thresh = 1'b0;

    always #5 clk_ext = ~clk_ext;

    dll_lock_ctrl dut (
        .clk_ext   (clk_ext),
        .Reset     (Reset),
        .en        (en),
        .start     (start),
        .M         (M),
        .N         (N),
        .COMP      (COMP),
        .Reset_PD  (Reset_PD),
        .M_counter (M_counter),
        .N_counter (N_counter),
        .Q         (Q),
        .Q_next    (Q_next),
        .lock      (lock),
        .busy      (busy)
    );

    typedef struct {
        logic       comp;
        logic       rpd;
        logic [1:0] mc;
        logic [3:0] nc;
        logic       bsy;
        int         q;
        int         qn;
    } vec_t;

    vec_t tbl [9];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // PD model: in threshold mode the delay is "too long" for any code above 613.
    task automatic step();
        @(posedge clk_ext);
        #1;
        if (comp_thresh) COMP = (Q > 10'd613);
    endtask

    task automatic wait_rpd(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!Reset_PD && n < 100);
        check("rpd_seen", int'(Reset_PD), 1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (busy && n < 100);
        check("idle_seen", int'(busy), 0);
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        step();
        Reset = 1'b0;
    endtask

    int n;
    int exp_q  [14] = '{612, 613, 612, 613, 612, 613, 614, 615, 616, 617, 616, 617, 616, 617};
    int exp_lk [14] = '{0, 0, 0, 0, 1, 1, 1, 1, 1, 0, 0, 0, 0, 1};
    logic trk_comp [14] = '{1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 1, 0, 1, 0};

    initial begin
        Reset = 1'b1; en = 1'b0; start = 1'b0; COMP = 1'b0; M = 2'd0; N = 4'd0;
        repeat (3) step();
        Reset = 1'b0;
        step();
        check("rst_q", int'(Q), 0);
        check("rst_cnt", int'({M_counter, N_counter}), 0);
        check("rst_flags", int'({lock, busy, Reset_PD}), 0);

        // Window sequencing with M=2, N=3, COMP held 1 for the first SAR trial
        tbl[0] = '{1'b1, 1'b1, 2'd1, 4'd1, 1'b1, 512, 512};
        tbl[1] = '{1'b1, 1'b0, 2'd1, 4'd1, 1'b1, 512, 512};
        tbl[2] = '{1'b1, 1'b0, 2'd1, 4'd2, 1'b1, 512, 512};
        tbl[3] = '{1'b1, 1'b0, 2'd1, 4'd3, 1'b1, 512, 512};
        tbl[4] = '{1'b1, 1'b0, 2'd2, 4'd1, 1'b1, 512, 512};
        tbl[5] = '{1'b1, 1'b0, 2'd2, 4'd2, 1'b1, 512, 512};
        tbl[6] = '{1'b1, 1'b0, 2'd2, 4'd3, 1'b1, 512, 512};
        tbl[7] = '{1'b1, 1'b0, 2'd2, 4'd3, 1'b1, 512, 256};
        tbl[8] = '{1'b1, 1'b1, 2'd1, 4'd1, 1'b1, 256, 256};
        M = 2'd2; N = 4'd3; en = 1'b1; COMP = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 9; i++) begin
            check($sformatf("win_rpd[%0d]", i), int'(Reset_PD), int'(tbl[i].rpd));
            check($sformatf("win_cnt[%0d]", i), int'({M_counter, N_counter}),
                  int'({tbl[i].mc, tbl[i].nc}));
            check($sformatf("win_busy[%0d]", i), int'(busy), int'(tbl[i].bsy));
            check($sformatf("win_q[%0d]", i), int'(Q), tbl[i].q);
            check($sformatf("win_qn[%0d]", i), int'(Q_next), tbl[i].qn);
            COMP = tbl[i].comp;
            step();
        end

        // Reset held three cycles in the middle of a window
        step();
        Reset = 1'b1;
        repeat (3) step();
        Reset = 1'b0;
        check("mid_rst_q", int'(Q), 0);
        check("mid_rst_cnt", int'({M_counter, N_counter}), 0);
        check("mid_rst_flags", int'({lock, busy, Reset_PD}), 0);
        repeat (3) step();
        check("mid_rst_stay_idle", int'(busy), 0);

        // SAR acquisition against the threshold model, 1-cycle windows
        M = 2'd0; N = 4'd0; comp_thresh = 1'b1; start = 1'b1;
        wait_rpd(n);
        start = 1'b0;
        check("sar_first_trial", int'(Q), 512);
        for (int k = 0; k < 10; k++) begin
            wait_rpd(n);
            if (k == 0) check("period_m0n0", n, 3);
            if (k == 8) check("sar_after9", int'(Q), 613);
        end
        check("sar_result", int'(Q), 613);
        check("sar_no_lock", int'(lock), 0);
        check("qnext_idle_eq", int'(Q_next), int'(Q));

        // Tracking: alternate to lock, climb to unlock, alternate to relock
        comp_thresh = 1'b0;
        for (int k = 0; k < 14; k++) begin
            COMP = trk_comp[k];
            wait_rpd(n);
            check($sformatf("trk_q[%0d]", k), int'(Q), exp_q[k]);
            check($sformatf("trk_lock[%0d]", k), int'(lock), exp_lk[k]);
        end

        // en dropped mid-window: one last update, then IDLE with Q and lock held
        COMP = 1'b1;
        step();
        en = 1'b0;
        wait_idle();
        check("en_drop_q", int'(Q), 616);
        check("en_drop_lock", int'(lock), 1);
        repeat (5) step();
        check("idle_hold", int'({busy, Reset_PD, Q}), int'({1'b0, 1'b0, 10'd616}));

        // Restart clears lock; start held while busy must not re-seed SAR
        en = 1'b1; start = 1'b1;
        wait_rpd(n);
        check("restart_lock", int'(lock), 0);
        check("restart_q", int'(Q), 512);
        wait_rpd(n);
        check("busy_start_period", n, 3);
        check("busy_start_q", int'(Q), 256);
        start = 1'b0;

        // Saturation at the top of the code range
        do_reset();
        COMP = 1'b0; start = 1'b1;
        wait_rpd(n);
        start = 1'b0;
        for (int k = 0; k < 12; k++) begin
            wait_rpd(n);
            if (k == 9) check("sat_hi_sar", int'(Q), 1023);
        end
        check("sat_hi_hold", int'(Q), 1023);
        check("sat_hi_lock", int'(lock), 0);

        // Saturation at zero
        do_reset();
        COMP = 1'b1; start = 1'b1;
        wait_rpd(n);
        start = 1'b0;
        for (int k = 0; k < 12; k++) begin
            wait_rpd(n);
            if (k == 9) check("sat_lo_sar", int'(Q), 0);
        end
        check("sat_lo_hold", int'(Q), 0);
        check("sat_lo_lock", int'(lock), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
